mem_access_unit: RTL and testbench

- Initiator-side controller that drives the byte-addressed, little-endian 32-bit data memory on behalf of the CPU datapath.
- Accepts one load/store request at a time over a valid/ready handshake and generates memR, memW, address and write data.
- Handles byte, halfword and word accesses: sign/zero extension on loads, read-modify-write for sub-word stores (the memory always writes 4 bytes), and alignment/range error detection.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory bus of the memory access unit.
// The master modport is the unit itself; the slave modport is the CPU/memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_Din;
  logic [31:0] mem_Dout;
  logic        memR;
  logic        memW;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_Dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_Din, memR, memW
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_Dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_Din, memR, memW
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a little-endian 32-bit data memory: sub-word loads with
// extension, read-modify-write sub-word stores, alignment and range checking.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rword_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, sgn_q, err_q;

  logic        req_err;
  logic [32:0] last_byte;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val, merge_word;

  logic accept;
  assign accept = (state_q == StIdle) && bus.req_valid;

  // Error priority: illegal size, half misaligned, word misaligned, out of range.
  always_comb begin
    case (bus.req_size)
      2'b00:   last_byte = {1'b0, bus.req_addr};
      2'b01:   last_byte = {1'b0, bus.req_addr} + 33'd1;
      default: last_byte = {1'b0, bus.req_addr} + 33'd3;
    endcase
    req_err = 1'b0;
    if (bus.req_size == 2'b11) begin
      req_err = 1'b1;
    end else if (bus.req_size == 2'b01 && bus.req_addr[0]) begin
      req_err = 1'b1;
    end else if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) begin
      req_err = 1'b1;
    end else if (last_byte >= 33'(MEM_BYTES)) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    ld_byte = bus.mem_Dout[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.mem_Dout[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: load_val = bus.mem_Dout;
    endcase
  end

  // Sub-word stores patch the word captured during the read cycle.
  always_comb begin
    merge_word = rword_q;
    case (size_q)
      2'b00:   merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = StResp;
          end else if (bus.req_we && bus.req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == StRd) begin
        rword_q <= bus.mem_Dout;
        if (!we_q) begin
          rdata_q <= load_val;
        end
      end
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.memR        = (state_q == StRd);
  assign bus.memW        = (state_q == StWr);
  assign bus.mem_address = (bus.memR || bus.memW) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_Din     = bus.memW ? merge_word : 32'h0;
  assign bus.resp_valid  = (state_q == StResp);
  assign bus.resp_err    = (state_q == StResp) && err_q;
  assign bus.resp_rdata  = (state_q == StResp) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference model, a memory beside the DUT and
// one per-cycle compare process, plus directed vectors with literal expectations.
module tb_mem_access_unit;

  localparam int MemBytes = 1024;
  localparam int MemWords = MemBytes / 4;

  typedef struct {
    int          rd_cyc;
    int          wr_cyc;
    int          resp_cyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] din;
    logic        do_wr;
    int          widx;
  } exp_t;

  logic clk;
  logic reset;
  logic init_mem;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0] mem [MemWords];
  logic [31:0] ref_mem [MemWords];
  exp_t        exp_arr [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          acc_last = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;
  logic [31:0] last_din = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return 32'h0000_0002;
    if (i == 1) return 32'h0000_0001;
    return {b, 8'hA5, 8'h5A, b};
  endfunction

  // Data memory: combinational read, write on the rising edge while memW is high.
  assign bus.mem_Dout = bus.memR ? mem[bus.mem_address[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MemWords; i++) mem[i] <= init_word(i);
    end else if (bus.memW) begin
      mem[bus.mem_address[9:2]] <= bus.mem_Din;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference model: works on individual bytes of the reference memory.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input int acc,
                       output exp_t e);
    int          n, sh;
    longint      last;
    logic [31:0] word, val;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    last = longint'(addr) + longint'(n) - 1;
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || (last >= MemBytes);
    e.rd_cyc = -1;
    e.wr_cyc = -1;
    e.rdata  = 32'h0;
    e.din    = 32'h0;
    e.do_wr  = 1'b0;
    e.addr   = addr & 32'hFFFF_FFFC;
    e.widx   = int'(addr[9:2]);
    if (e.err) begin
      e.resp_cyc = acc;
    end else begin
      word = ref_mem[e.widx];
      sh   = int'(addr[1:0]);
      if (!we) begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val |= ((word >> (8 * (sh + i))) & 32'hFF) << (8 * i);
        if (sgn && n < 4 && val[8*n-1]) val |= ~((32'h1 << (8 * n)) - 32'h1);
        e.rdata    = val;
        e.rd_cyc   = acc;
        e.resp_cyc = acc + 1;
      end else begin
        for (int i = 0; i < n; i++) begin
          word = (word & ~(32'hFF << (8 * (sh + i)))) |
                 (((wdata >> (8 * i)) & 32'hFF) << (8 * (sh + i)));
        end
        e.din   = word;
        e.do_wr = 1'b1;
        if (n == 4) begin
          e.wr_cyc   = acc;
          e.resp_cyc = acc + 1;
        end else begin
          e.rd_cyc   = acc;
          e.wr_cyc   = acc + 1;
          e.resp_cyc = acc + 2;
        end
      end
    end
  endtask

  // Compare process: every cycle outside reset, all outputs against the model.
  always @(negedge clk) begin
    logic        er, ew;
    logic [31:0] ea, ed;
    if (init_mem) begin
      for (int i = 0; i < MemWords; i++) ref_mem[i] = init_word(i);
    end else if (reset) begin
      rd_ptr = wr_ptr;
    end else begin
      er = 1'b0; ew = 1'b0; ea = 32'h0; ed = 32'h0;
      for (int k = rd_ptr; k < wr_ptr; k++) begin
        if (exp_arr[k].rd_cyc == cyc) begin er = 1'b1; ea = exp_arr[k].addr; end
        if (exp_arr[k].wr_cyc == cyc) begin
          ew = 1'b1; ea = exp_arr[k].addr; ed = exp_arr[k].din;
        end
      end
      chk("memR", bus.memR, er);
      chk("memW", bus.memW, ew);
      chk("mem_address", bus.mem_address, ea);
      chk("mem_Din", bus.mem_Din, ed);
      chk("req_ready", bus.req_ready, rd_ptr == wr_ptr);
      if (bus.memW) last_din = bus.mem_Din;
      if (rd_ptr < wr_ptr && exp_arr[rd_ptr].resp_cyc < cyc) begin
        chk("resp_missed", 32'(exp_arr[rd_ptr].resp_cyc), 32'(cyc));
        rd_ptr++;
      end
      if (rd_ptr < wr_ptr && exp_arr[rd_ptr].resp_cyc == cyc) begin
        chk("resp_valid", bus.resp_valid, 1'b1);
        chk("resp_err", bus.resp_err, exp_arr[rd_ptr].err);
        chk("resp_rdata", bus.resp_rdata, exp_arr[rd_ptr].rdata);
        last_rdata    = bus.resp_rdata;
        last_err      = bus.resp_err;
        last_resp_cyc = cyc;
        if (exp_arr[rd_ptr].do_wr) ref_mem[exp_arr[rd_ptr].widx] = exp_arr[rd_ptr].din;
        rd_ptr++;
      end else begin
        chk("resp_valid_idle", bus.resp_valid, 1'b0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    acc_last = cyc;
    model(we, size, sgn, addr, wdata, cyc, e);
    exp_arr[wr_ptr] = e;
    wr_ptr++;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_req();
    int t;
    t = 0;
    while (rd_ptr != wr_ptr && t < 20) begin @(negedge clk); t++; end
    if (rd_ptr != wr_ptr) chk("resp_timeout", 32'(rd_ptr), 32'(wr_ptr));
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata);
    issue(we, size, sgn, addr, wdata);
    finish_req();
  endtask

  initial begin
    exp_t e;
    int   diffs;
    init_mem       = 1'b1;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_memR", bus.memR, 1'b0);
    chk("rst_memW", bus.memW, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_Din", bus.mem_Din, 32'h0);
    init_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
    chk("lit_load_w0", last_rdata, 32'h0000_0002);
    chk("lat_load", 32'(last_resp_cyc - acc_last), 32'd1);

    run(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF);
    chk("lat_wstore", 32'(last_resp_cyc - acc_last), 32'd1);
    run(1'b0, 2'b00, 1'b1, 32'd11, 32'h0);
    chk("lit_lb_11", last_rdata, 32'hFFFF_FFDE);
    run(1'b0, 2'b01, 1'b0, 32'd10, 32'h0);
    chk("lit_lhu_10", last_rdata, 32'h0000_DEAD);

    run(1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFF_FF55);
    chk("lit_sb_din", last_din, 32'h0000_5501);
    chk("lat_sbstore", 32'(last_resp_cyc - acc_last), 32'd2);
    run(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    chk("lit_load_w4", last_rdata, 32'h0000_5501);

    run(1'b0, 2'b01, 1'b0, 32'd3, 32'h0);
    chk("lit_err_half3", last_err, 1'b1);
    chk("lat_err", 32'(last_resp_cyc - acc_last), 32'd0);
    run(1'b1, 2'b10, 1'b0, 32'd6, 32'h1234_5678);
    chk("lit_err_word6", last_err, 1'b1);
    run(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
    chk("lit_err_size3", last_err, 1'b1);
    run(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
    chk("lit_err_range", last_err, 1'b1);
    run(1'b1, 2'b00, 1'b0, 32'd1024, 32'h0000_0011);
    chk("lit_err_byte1024", last_err, 1'b1);

    run(1'b0, 2'b10, 1'b0, 32'd1020, 32'h0);
    chk("lit_load_1020", last_rdata, 32'hFFA5_5AFF);
    run(1'b1, 2'b00, 1'b0, 32'd1023, 32'h0000_007F);
    run(1'b0, 2'b00, 1'b1, 32'd1023, 32'h0);
    chk("lit_lb_1023", last_rdata, 32'h0000_007F);
    run(1'b0, 2'b00, 1'b1, 32'd1020, 32'h0);
    chk("lit_lb_1020", last_rdata, 32'hFFFF_FFFF);
    run(1'b0, 2'b01, 1'b1, 32'd1022, 32'h0);
    chk("lit_lh_1022", last_rdata, 32'h0000_7FA5);

    run(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000_BEEF);
    run(1'b0, 2'b01, 1'b1, 32'd2, 32'h0);
    chk("lit_lh_2", last_rdata, 32'hFFFF_BEEF);

    // Back-to-back loads with req_valid held high throughout.
    issue(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    model(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, cyc, e);
    exp_arr[wr_ptr] = e;
    wr_ptr++;
    bus.req_valid = 1'b0;
    finish_req();
    chk("lit_b2b_second", last_rdata, 32'h0000_5501);

    // Reset during the write cycle of a word store: the write must not happen.
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFE_F00D);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_memW", bus.memW, 1'b0);
    chk("rst_mid_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_mid_resp", bus.resp_valid, 1'b0);
    chk("rst_mid_mem0", mem[0], 32'hBEEF_0002);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
    chk("lit_after_rst", last_rdata, 32'hBEEF_0002);

    diffs = 0;
    for (int i = 0; i < MemWords; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_final", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
